pf_window_acc: RTL and testbench

- Upstream feeder for the signed 8-bit fixed-point divider stage.
- Accumulates a window of signed 8-bit samples over a valid/ready stream.
- On window close, presents a saturated signed sum as `numerator` and the sample count as `denominator`. The divider's Q4.4 result is then the window mean.
- Holds the pair stable under output backpressure and flags sum saturation.

---
 rtl/pf_pkg.sv | 45 ++++
 rtl/pf_sat8.sv | 21 ++
 rtl/pf_window_acc.sv | 178 +++++++++++++++++
 tb/tb_pf_window_acc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pf_pkg.sv
// Shared definitions for the pf fixed-point pipeline stages: state encoding,
// data/accumulator widths and the signed 16-to-8 saturation helper.
package pf_pkg;

  // Width of the fixed-point samples and results exchanged between stages.
  localparam int PF_DATA_W = 8;

  // Width of the wide accumulation path fed into the 8-bit clipper.
  localparam int PF_ACC_W = 16;

  // Clip limits expressed at accumulator width, so comparisons stay signed
  // and width-matched.
  localparam logic signed [PF_ACC_W-1:0] PF_SAT_MAX = 16'sd127;
  localparam logic signed [PF_ACC_W-1:0] PF_SAT_MIN = -16'sd128;

  // Window accumulator control states.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } pf_state_e;

  // Result of saturating a wide value into the 8-bit data format.
  typedef struct packed {
    logic                 sat;
    logic [PF_DATA_W-1:0] value;
  } pf_sat8_t;

  // Clip a signed accumulator-width value to [-128, 127] and report whether
  // clipping took place. Reused by every stage that narrows a wide result.
  function automatic pf_sat8_t pf_saturate8(input logic signed [PF_ACC_W-1:0] wide);
    pf_sat8_t res;
    if (wide > PF_SAT_MAX) begin
      res.value = 8'h7f;
      res.sat   = 1'b1;
    end else if (wide < PF_SAT_MIN) begin
      res.value = 8'h80;
      res.sat   = 1'b1;
    end else begin
      res.value = wide[PF_DATA_W-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/pf_sat8.sv
// Combinational signed clipper: narrows a 16-bit two's-complement value to
// 8 bits, saturating at the format limits and flagging when it had to.
module pf_sat8
  import pf_pkg::*;
(
  input  logic signed [PF_ACC_W-1:0]  wide,
  output logic signed [PF_DATA_W-1:0] value,
  output logic                        sat
);

  pf_sat8_t res;

  // Evaluate the shared saturation helper on the wide input.
  always_comb begin
    res = pf_saturate8(wide);
  end

  assign value = res.value;
  assign sat   = res.sat;

endmodule

// File: rtl/pf_window_acc.sv
// Window accumulator feeding the signed 8-bit divider. Sums signed samples
// over a window closed by in_last, by reaching MAX_COUNT, or by flush, then
// holds a saturated sum (numerator) and sample count (denominator) until the
// downstream stage takes them.
module pf_window_acc
  import pf_pkg::*;
#(
  parameter int MAX_COUNT = 15,
  parameter int ACC_W     = PF_ACC_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [PF_DATA_W-1:0] in_data,
  input  logic                        in_last,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [PF_DATA_W-1:0] numerator,
  output logic signed [PF_DATA_W-1:0] denominator,
  output logic                        sat
);

  // Count register is wide enough for the largest legal MAX_COUNT (127).
  localparam int                CNT_W   = 7;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_COUNT);

  pf_state_e                     state_r;
  pf_state_e                     state_nxt_s;

  logic signed [ACC_W-1:0]       acc_r;
  logic signed [ACC_W-1:0]       acc_nxt_s;
  logic signed [ACC_W-1:0]       sample_ext_s;
  logic [CNT_W-1:0]              cnt_r;
  logic [CNT_W-1:0]              cnt_nxt_s;

  logic                          accept_s;
  logic                          close_s;

  logic signed [PF_ACC_W-1:0]    clip_in_s;
  logic signed [PF_DATA_W-1:0]   clip_value_s;
  logic                          clip_sat_s;

  logic signed [PF_DATA_W-1:0]   numerator_r;
  logic signed [PF_DATA_W-1:0]   denominator_r;
  logic                          sat_r;

  assign sample_ext_s = {{(ACC_W-PF_DATA_W){in_data[PF_DATA_W-1]}}, in_data};

  // With at most 127 samples of magnitude <= 128 the exact sum always fits in
  // 16 bits, so any extra accumulator bits are pure sign extension and
  // dropping them before the clipper is lossless.
  assign clip_in_s = acc_nxt_s[PF_ACC_W-1:0];

  // Work out acceptance, the post-sample accumulator/count and window close.
  always_comb begin
    accept_s  = 1'b0;
    close_s   = 1'b0;
    acc_nxt_s = acc_r;
    cnt_nxt_s = cnt_r;
    if (state_r == ACCUM) begin
      accept_s = in_valid;
      if (in_valid) begin
        acc_nxt_s = acc_r + sample_ext_s;
        cnt_nxt_s = cnt_r + 7'd1;
      end else begin
        acc_nxt_s = acc_r;
        cnt_nxt_s = cnt_r;
      end
      close_s = (in_valid && (in_last || (cnt_nxt_s == CNT_MAX))) || flush;
    end else begin
      accept_s = 1'b0;
      close_s  = 1'b0;
    end
  end

  pf_sat8 u_sat8 (
    .wide  (clip_in_s),
    .value (clip_value_s),
    .sat   (clip_sat_s)
  );

  // State register: ACCUM while collecting a window, HOLD while presenting it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: close a window into HOLD; leave HOLD only on a handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM: begin
        if (close_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = ACCUM;
      end
    endcase
  end

  // Handshake outputs decode straight from the state register, so nothing
  // from the input side reaches them combinationally. No bypass: in_ready
  // stays low through the HOLD handoff cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      ACCUM: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Running sum and count: cleared on close, updated on each accepted sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
      cnt_r <= 7'd0;
    end else if (close_s) begin
      acc_r <= '0;
      cnt_r <= 7'd0;
    end else if (accept_s) begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_nxt_s;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // Result registers: captured on close (closing sample included) and frozen
  // otherwise; only out_valid says whether they are current.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      numerator_r   <= 8'sd0;
      denominator_r <= 8'sd0;
      sat_r         <= 1'b0;
    end else if (close_s) begin
      numerator_r   <= clip_value_s;
      denominator_r <= {1'b0, cnt_nxt_s};
      sat_r         <= clip_sat_s;
    end else begin
      numerator_r   <= numerator_r;
      denominator_r <= denominator_r;
      sat_r         <= sat_r;
    end
  end

  assign numerator   = numerator_r;
  assign denominator = denominator_r;
  assign sat         = sat_r;

endmodule

// File: tb/tb_pf_window_acc.sv
// Scoreboard bench for pf_window_acc: a window-level reference model predicts
// each emitted pair and the handshake levels; a separate monitor compares.
module tb_pf_window_acc;

  localparam int MC = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              in_last;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] numerator;
  logic signed [7:0] denominator;
  logic              sat;

  pf_window_acc #(.MAX_COUNT(MC), .ACC_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .numerator   (numerator),
    .denominator (denominator),
    .sat         (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int num;
    int den;
    int sat;
  } exp_t;

  int   win_q[$];     // samples of the window being collected
  exp_t exp_q[$];     // pairs expected on the output, oldest first
  bit   model_hold;   // a closed window is waiting for the downstream
  bit   mon_en;
  bit   rst_chk;
  int   passes;
  int   total;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window-level reference: one call per clock edge with the inputs applied.
  task automatic model_step(input bit v, input int d, input bit l, input bit f, input bit ordy);
    logic signed [7:0] b;
    int s;
    exp_t e;
    b = d[7:0];
    if (model_hold) begin
      if (ordy) model_hold = 1'b0;
    end else begin
      if (v) win_q.push_back(int'(b));
      if ((v && l) || (win_q.size() == MC) || f) begin
        s = 0;
        foreach (win_q[k]) s += win_q[k];
        e.num = (s > 127) ? 127 : ((s < -128) ? -128 : s);
        e.sat = (e.num != s) ? 1 : 0;
        e.den = win_q.size();
        exp_q.push_back(e);
        win_q.delete();
        model_hold = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit v, input int d, input bit l, input bit f, input bit ordy);
    in_valid  = v;
    in_data   = d[7:0];
    in_last   = l;
    flush     = f;
    out_ready = ordy;
    @(posedge clk);
    model_step(v, d, l, f, ordy);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'sd11;
    in_last   = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    win_q.delete();
    exp_q.delete();
    model_hold = 1'b0;
    rst_chk    = 1'b1;
    mon_en     = 1'b1;
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  // Monitor: compare handshake levels and the presented pair against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", int'(out_valid), int'(model_hold));
      chk("in_ready", int'(in_ready), int'(!model_hold));
      if (rst_chk) begin
        chk("reset_numerator", int'(numerator), 0);
        chk("reset_denominator", int'(denominator), 0);
        chk("reset_sat", int'(sat), 0);
        rst_chk = 1'b0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", 1, 0);
        end else begin
          chk("numerator", int'(numerator), exp_q[0].num);
          chk("denominator", int'(denominator), exp_q[0].den);
          chk("sat", int'(sat), exp_q[0].sat);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = 8'sd0;
    in_last = 1'b0; flush = 1'b0; out_ready = 1'b0;
    passes = 0; total = 0; mon_en = 1'b0; rst_chk = 1'b0; model_hold = 1'b0;

    do_reset();
    drive(0, 0, 0, 0, 0);

    // 10, 20, 30 with last; immediate handoff.
    drive(1, 10, 0, 0, 1); drive(1, 20, 0, 0, 1); drive(1, 30, 1, 0, 1);
    drive(1, 99, 0, 0, 1); drive(0, 0, 0, 0, 1);

    // Positive and negative saturation, and an in-range excursion.
    for (int i = 0; i < 4; i++) drive(1, 100, (i == 3), 0, 1);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, -100, (i == 3), 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(1, 100, 0, 0, 1); drive(1, 100, 0, 0, 1); drive(1, -100, 1, 0, 1);
    drive(0, 0, 0, 0, 1);

    // Auto-close at MC with a 5-cycle stall while sample 5 waits.
    for (int i = 1; i <= 4; i++) drive(1, i, 0, 0, 0);
    repeat (5) drive(1, 5, 0, 0, 0);
    drive(1, 5, 0, 0, 1);
    drive(1, 5, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);

    // Empty flush, flush together with a sample, flush ignored in HOLD.
    drive(0, 0, 0, 1, 1); drive(0, 0, 0, 1, 1);
    drive(1, 7, 0, 1, 0); drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 1);   // in_last without in_valid is ignored
    drive(0, 0, 0, 1, 1); drive(0, 0, 0, 0, 1);

    // Reset mid-window, then a fresh one-sample window.
    drive(1, 5, 0, 0, 1); drive(1, 6, 0, 0, 1);
    do_reset();
    drive(1, 3, 1, 0, 1); drive(0, 0, 0, 0, 1);

    // Reset during HOLD under backpressure: pending pair is dropped.
    drive(1, 9, 1, 0, 0); drive(0, 0, 0, 0, 0);
    do_reset();
    drive(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 99) < 70, int'($urandom_range(0, 255)),
              $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 6);
      end
    end

    repeat (3) drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
